// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

    localparam int PC_W        = 32;
    localparam int INST_W      = 32;
    localparam int FETCH_BYTES = 8;

    // One decoded-order slot handed to decode: the instruction and where it came from.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // An 8-byte aligned PC fetches a full pair; a PC sitting on the upper word
    // only yields one instruction, so it steps by 4 to realign.
    function automatic logic [PC_W-1:0] next_fetch_pc(input logic [PC_W-1:0] pc);
        return pc + (pc[2] ? PC_W'(4) : PC_W'(FETCH_BYTES));
    endfunction

endpackage

// File: rtl/fetch_queue_2w.sv
// Circular FIFO of fetch entries that can accept two and release two per cycle.
module fetch_queue_2w
    import if_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [1:0]       enq_n,
    input  fetch_entry_t     enq0,
    input  fetch_entry_t     enq1,
    input  logic [1:0]       deq_n,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head0,
    output fetch_entry_t     head1
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr1;
    logic [PTR_W-1:0] wr_ptr1;
    logic [CNT_W-1:0] enq_w;
    logic [CNT_W-1:0] deq_eff;
    logic [CNT_W-1:0] count_next;

    assign rd_ptr1 = rd_ptr + PTR_W'(1);
    assign wr_ptr1 = wr_ptr + PTR_W'(1);

    // Clamp both request widths to two and never release more than is stored.
    always_comb begin
        enq_w   = enq_n[1] ? CNT_W'(2) : CNT_W'(enq_n);
        deq_eff = deq_n[1] ? CNT_W'(2) : CNT_W'(deq_n);
        if (deq_eff > count) begin
            deq_eff = count;
        end
        count_next = count + enq_w - deq_eff;
    end

    // Pointer and occupancy bookkeeping; a clear drops everything by catching up rd_ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(deq_eff);
            wr_ptr <= wr_ptr + PTR_W'(enq_w);
            count  <= count_next;
        end
    end

    // Storage writes: slot0 at wr_ptr, slot1 right behind it, wrapping modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            if (enq_w != '0) begin
                mem[wr_ptr] <= enq0;
            end
            if (enq_w == CNT_W'(2)) begin
                mem[wr_ptr1] <= enq1;
            end
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr1];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch requester: drives the icache PC, splits returned pairs into entries, feeds decode.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   icache_pc,
    output logic              icache_stall,
    output logic              icache_flush,
    input  logic              icache_valid,
    input  logic [63:0]       icache_ir,
    input  logic              icache_flag,
    output logic              out0_valid,
    output logic              out1_valid,
    output logic [PC_W-1:0]   out0_pc,
    output logic [PC_W-1:0]   out1_pc,
    output logic [INST_W-1:0] out0_inst,
    output logic [INST_W-1:0] out1_inst,
    input  logic [1:0]        deq_num
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  resp_pc_q;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic [1:0]       enq_n;
    logic [1:0]       deq_n;
    fetch_entry_t     enq0;
    fetch_entry_t     enq1;
    fetch_entry_t     head0;
    fetch_entry_t     head1;

    // Stall looks only at registered occupancy so the icache hold has no path from decode.
    assign icache_stall = count > CNT_W'(DEPTH - 2);
    assign icache_flush = rst | redirect_valid;
    assign accept       = icache_valid & ~icache_stall & ~redirect_valid & ~rst;
    assign icache_pc    = pc_q;

    // Split the accepted pair into entries; a redirect also cancels this cycle's dequeue.
    always_comb begin
        enq_n = 2'd0;
        if (accept) begin
            enq_n = icache_flag ? 2'd2 : 2'd1;
        end
        enq0.pc   = resp_pc_q;
        enq0.inst = icache_ir[63:32];
        enq1.pc   = resp_pc_q + PC_W'(4);
        enq1.inst = icache_ir[31:0];
        deq_n     = redirect_valid ? 2'd0 : deq_num;
    end

    // Fetch PC and the PC of the response now in the icache output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[PC_W-1:2], 2'b00};
        end else if (!icache_stall) begin
            pc_q      <= next_fetch_pc(pc_q);
            resp_pc_q <= pc_q;
        end
    end

    fetch_queue_2w #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_valid),
        .enq_n (enq_n),
        .enq0  (enq0),
        .enq1  (enq1),
        .deq_n (deq_n),
        .count (count),
        .head0 (head0),
        .head1 (head1)
    );

    assign out0_valid = count != '0;
    assign out1_valid = count > CNT_W'(1);
    assign out0_pc    = head0.pc;
    assign out0_inst  = head0.inst;
    assign out1_pc    = head1.pc;
    assign out1_inst  = head1.inst;

endmodule
